seq_stage_sequencer: RTL and testbench
======================================

// Module: seq_stage_sequencer
// PURPOSE
//  Multi-cycle control unit for the Y86-64 SEQ core. Steps one instruction through
//  fetch/decode/execute/memory/writeback/pc-update with one-hot stage enables,
//  owns the ZF/SF/OF condition-code register and the architectural Stat register.
//  Replaces simulation-only $finish stopping with a synthesizable HALTED state.
//  Adds memory wait-state handshake with timeout and an optional instruction limit.
// PARAMETERS
//  CNT_W        32  width of cycle/instruction counters
//  MEM_TIMEOUT  16  max cycles in MEMORY waiting for mem_ready before ADR fault (>=1)
//  MAX_INSTR    0   stop with HLT after this many retired instructions; 0 = unlimited
// PORTS
//  clk          in   1      clock, all state on rising edge
//  reset        in   1      synchronous, active-high
//  start        in   1      level; leaves IDLE when 1
//  icode        in   4      current instruction code from fetch
//  imem_error   in   1      fetch address fault
//  instr_valid  in   1      fetch decoded a legal icode/ifun
//  halt_instr   in   1      fetch saw halt
//  dmem_error   in   1      data memory address fault
//  mem_ready    in   1      data memory access complete
//  alu_zf/sf/of in   1 each flags produced by execute
//  stage_en     out  6      one-hot {pc,wb,mem,exe,dec,fet}; bit0 = fetch
//  zf, sf, of   out  1 each condition-code register
//  stat         out  3      1=AOK 2=HLT 3=ADR 4=INS
//  running      out  1      1 in any stage state
//  done         out  1      1 in HALTED
//  cycle_count  out  CNT_W  cycles spent outside IDLE/HALTED
//  instr_count  out  CNT_W  instructions retired (PC-update completed)
// BEHAVIOUR
//  Reset: state IDLE, stage_en=0, zf=1 sf=0 of=0, stat=AOK, running=0, done=0, counts=0.
//  Reset wins over every other event, including mid-instruction and in HALTED.
//  States: IDLE->FETCH (start=1) ->DECODE->EXECUTE->MEMORY->WB->PCUPD->FETCH.
//  stage_en is registered: exactly one bit high per stage state, 0 in IDLE/HALTED.
//  Each stage lasts 1 cycle except MEMORY; unstalled instruction = 6 cycles.
//  End of FETCH, priority order: imem_error->stat=ADR; else !instr_valid->INS;
//   else halt_instr->HLT; any of these -> HALTED next cycle, no further enables.
//  EXECUTE: if icode==4'h6 (OPq) latch {zf,sf,of}<={alu_zf,alu_sf,alu_of}; else hold.
//  MEMORY: stays while mem_ready=0; internal wait counter starts at 0 on entry.
//   mem_ready=1 and dmem_error=0 -> WB. dmem_error=1 (any cycle) -> stat=ADR, HALTED.
//   dmem_error and mem_ready same cycle: error wins. Wait counter reaching
//   MEM_TIMEOUT-1 with mem_ready=0 -> stat=ADR, HALTED. WB/PCUPD skipped on fault.
//  PCUPD: instr_count increments on exit. If MAX_INSTR!=0 and new count==MAX_INSTR
//   -> stat=HLT, HALTED; else FETCH.
//  HALTED is absorbing until reset; start ignored. stat frozen, done=1.
//  Counters wrap modulo 2^CNT_W; no saturation.
// CONFIGURATION
//  SEQ_PERF_CNT_EN defined: cycle_count/instr_count implemented as above.
//  Undefined: both outputs tied to 0, no counter flops; MAX_INSTR limit still
//   enforced via a private retire counter only when MAX_INSTR!=0.
// STRUCTURE
//  Package seq_pkg: stat codes (STAT_AOK/HLT/ADR/INS), state enum, icode constants
//   (I_HALT=0, I_OPQ=6, ...), stage_en bit indices.
//  Sub-module seq_perf_cnt (clk, reset, inc, count[CNT_W]) instanced for both counters.
//  Single always block for state/stat/CC; wait counter width $clog2(MEM_TIMEOUT+1).
// TESTING
//  OPq retire, mem_ready tied 1: 6 cycles per instr, stage_en 01,02,04,08,10,20 repeat,
//   instr_count=1 after first PCUPD, flags load alu values only on icode=6.
//  halt_instr=1 in 3rd fetch -> stat=2, done=1, instr_count=2, stage_en=0 thereafter.
//  imem_error=1 with instr_valid=0 and halt_instr=1 same fetch -> stat=3 (ADR priority).
//  mem_ready low 5 cycles then high -> MEMORY 6 cycles, stat stays 1; low for
//   MEM_TIMEOUT=16 cycles -> stat=3, no WB/PC enable issued.
//  MAX_INSTR=3 -> HALTED after third PCUPD, stat=2, instr_count=3.
//  reset asserted in EXECUTE -> next cycle IDLE, zf=1, counters 0; start resumes FETCH.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared stat codes, sequencer states, Y86-64 icodes and stage enable bit indices
package seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WB,
    S_PCUPD,
    S_HALTED
  } state_e;
  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'ha;
  localparam logic [3:0] I_POPQ   = 4'hb;
  localparam int EN_FET = 0;
  localparam int EN_DEC = 1;
  localparam int EN_EXE = 2;
  localparam int EN_MEM = 3;
  localparam int EN_WB  = 4;
  localparam int EN_PC  = 5;
  function automatic logic [5:0] stage_onehot(input state_e s);
    logic [5:0] en;
    en = '0;
    en[EN_FET] = (s == S_FETCH);
    en[EN_DEC] = (s == S_DECODE);
    en[EN_EXE] = (s == S_EXECUTE);
    en[EN_MEM] = (s == S_MEMORY);
    en[EN_WB]  = (s == S_WB);
    en[EN_PC]  = (s == S_PCUPD);
    return en;
  endfunction
endpackage

// File: rtl/seq_perf_cnt.sv
// seq_perf_cnt: wrapping up-counter with synchronous clear, one step per cycle when inc is high
module seq_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;
  always_comb count_d = inc ? count_q + CNT_W'(1) : count_q;
  always_ff @(posedge clk)
    if (reset) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/seq_stage_sequencer.sv
// seq_stage_sequencer: multi-cycle SEQ stage FSM with CC/Stat registers, memory timeout and retire limit.
// Define SEQ_PERF_CNT_EN to build the cycle/instruction performance counters.
module seq_stage_sequencer
  import seq_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int MAX_INSTR   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             imem_error,
  input  logic             instr_valid,
  input  logic             halt_instr,
  input  logic             dmem_error,
  input  logic             mem_ready,
  input  logic             alu_zf,
  input  logic             alu_sf,
  input  logic             alu_of,
  output logic [5:0]       stage_en,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic [2:0]       stat,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  state_e            state_q, state_d;
  stat_e             stat_q, stat_d;
  logic [2:0]        cc_q, cc_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [5:0]        stage_en_q;
  logic [CNT_W-1:0]  retire_cnt;
  logic              limit_hit;
  assign limit_hit = (MAX_INSTR != 0) && (retire_cnt + CNT_W'(1) == CNT_W'(MAX_INSTR));
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    cc_d    = cc_q;
    wait_d  = '0;
    unique case (state_q)
      S_IDLE:    state_d = start ? S_FETCH : S_IDLE;
      S_FETCH: begin
        stat_d  = imem_error ? STAT_ADR :
                  !instr_valid ? STAT_INS :
                  halt_instr ? STAT_HLT : STAT_AOK;
        state_d = (imem_error || !instr_valid || halt_instr) ? S_HALTED : S_DECODE;
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: begin
        state_d = S_MEMORY;
        cc_d    = (icode == I_OPQ) ? {alu_zf, alu_sf, alu_of} : cc_q;
      end
      S_MEMORY: begin
        // a data fault beats a simultaneous ready; the wait counter bounds a stuck access
        if (dmem_error || (!mem_ready && wait_q == WAIT_W'(MEM_TIMEOUT - 1))) begin
          stat_d  = STAT_ADR;
          state_d = S_HALTED;
        end else if (mem_ready) state_d = S_WB;
        else wait_d = wait_q + WAIT_W'(1);
      end
      S_WB:      state_d = S_PCUPD;
      S_PCUPD: begin
        stat_d  = limit_hit ? STAT_HLT : STAT_AOK;
        state_d = limit_hit ? S_HALTED : S_FETCH;
      end
      S_HALTED:  state_d = S_HALTED;
      default:   state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q    <= S_IDLE;
      stat_q     <= STAT_AOK;
      cc_q       <= 3'b100;
      wait_q     <= '0;
      stage_en_q <= '0;
    end else begin
      state_q    <= state_d;
      stat_q     <= stat_d;
      cc_q       <= cc_d;
      wait_q     <= wait_d;
      stage_en_q <= stage_onehot(state_d);
    end
  assign stage_en     = stage_en_q;
  assign {zf, sf, of} = cc_q;
  assign stat         = stat_q;
  assign running      = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign done         = (state_q == S_HALTED);
`ifdef SEQ_PERF_CNT_EN
  seq_perf_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (running),
    .count (cycle_count)
  );
  seq_perf_cnt #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (state_q == S_PCUPD),
    .count (retire_cnt)
  );
  assign instr_count = retire_cnt;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
  if (MAX_INSTR != 0) begin : g_retire
    seq_perf_cnt #(.CNT_W(CNT_W)) u_retire_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (state_q == S_PCUPD),
      .count (retire_cnt)
    );
  end else begin : g_no_retire
    assign retire_cnt = '0;
  end
`endif
endmodule

// File: tb/tb_seq_stage_sequencer.sv
// tb_seq_stage_sequencer: directed checks of stage stepping, faults, wait states, limit and reset
module tb_seq_stage_sequencer;
`ifdef SEQ_PERF_CNT_EN
  localparam logic PERF = 1'b1;
`else
  localparam logic PERF = 1'b0;
`endif
  logic        clk, reset, lim_reset, start;
  logic [3:0]  icode;
  logic        imem_error, instr_valid, halt_instr, dmem_error, mem_ready;
  logic        alu_zf, alu_sf, alu_of;
  logic [5:0]  stage_en, lim_stage_en;
  logic        zf, sf, of, lim_zf, lim_sf, lim_of;
  logic [2:0]  stat, lim_stat;
  logic        running, done, lim_running, lim_done;
  logic [31:0] cycle_count, instr_count, lim_cycle_count, lim_instr_count;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [5:0]  seq_exp [6];
  seq_stage_sequencer #(.CNT_W(32), .MEM_TIMEOUT(16), .MAX_INSTR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .icode(icode), .imem_error(imem_error),
    .instr_valid(instr_valid), .halt_instr(halt_instr), .dmem_error(dmem_error),
    .mem_ready(mem_ready), .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
    .stage_en(stage_en), .zf(zf), .sf(sf), .of(of), .stat(stat), .running(running),
    .done(done), .cycle_count(cycle_count), .instr_count(instr_count)
  );
  seq_stage_sequencer #(.CNT_W(32), .MEM_TIMEOUT(16), .MAX_INSTR(3)) dut_lim (
    .clk(clk), .reset(lim_reset), .start(start), .icode(icode), .imem_error(imem_error),
    .instr_valid(instr_valid), .halt_instr(halt_instr), .dmem_error(dmem_error),
    .mem_ready(mem_ready), .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
    .stage_en(lim_stage_en), .zf(lim_zf), .sf(lim_sf), .of(lim_of), .stat(lim_stat),
    .running(lim_running), .done(lim_done), .cycle_count(lim_cycle_count),
    .instr_count(lim_instr_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic go_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask
  function automatic logic [63:0] pc(input int n);
    return PERF ? 64'(n) : 64'd0;
  endfunction
  initial begin
    reset = 1'b1; lim_reset = 1'b1; start = 1'b0; icode = 4'h6;
    imem_error = 1'b0; instr_valid = 1'b1; halt_instr = 1'b0; dmem_error = 1'b0;
    mem_ready = 1'b1; alu_zf = 1'b0; alu_sf = 1'b1; alu_of = 1'b1;
    seq_exp = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
    step(2);
    reset = 1'b0;
    chk("rst_stage_en", stage_en, 0);
    chk("rst_cc", {zf, sf, of}, 3'b100);
    chk("rst_stat", stat, 1);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_instr_count", instr_count, 0);
    chk("lim_rst_stat", lim_stat, 1);
    step(1);
    chk("idle_no_start", stage_en, 0);
    start = 1'b1;
    step(1);
    chk("fetch1_en", stage_en, 6'h01);
    chk("fetch1_running", running, 1);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("opq_stage_seq", stage_en, seq_exp[i]);
      if (i == 2) chk("opq_cc_load", {zf, sf, of}, 3'b011);
    end
    chk("instr_count_1", instr_count, pc(1));
    chk("cycle_count_6", cycle_count, pc(6));
    icode = 4'h2; alu_zf = 1'b1; alu_sf = 1'b0; alu_of = 1'b0; mem_ready = 1'b0;
    step(3);
    chk("mov_mem_entry", stage_en, 6'h08);
    chk("mov_cc_hold", {zf, sf, of}, 3'b011);
    step(5);
    chk("wait_still_mem", stage_en, 6'h08);
    chk("wait_stat_aok", stat, 1);
    mem_ready = 1'b1;
    step(1);
    chk("wait_release_wb", stage_en, 6'h10);
    step(2);
    chk("fetch3_en", stage_en, 6'h01);
    chk("instr_count_2", instr_count, pc(2));
    chk("cycle_count_17", cycle_count, pc(17));
    halt_instr = 1'b1;
    step(1);
    chk("halt_stat", stat, 2);
    chk("halt_done", done, 1);
    chk("halt_stage_en", stage_en, 0);
    step(3);
    chk("halted_absorb_en", stage_en, 0);
    chk("halted_absorb_done", done, 1);
    chk("halted_running", running, 0);
    chk("halted_instr_count", instr_count, pc(2));
    chk("halted_cycle_count", cycle_count, pc(18));
    go_reset();
    chk("reset_from_halt_done", done, 0);
    chk("reset_from_halt_stat", stat, 1);
    imem_error = 1'b1; instr_valid = 1'b0;
    step(2);
    chk("adr_priority_stat", stat, 3);
    chk("adr_priority_en", stage_en, 0);
    imem_error = 1'b0;
    go_reset();
    step(2);
    chk("ins_stat", stat, 4);
    chk("ins_done", done, 1);
    instr_valid = 1'b1; halt_instr = 1'b0;
    go_reset();
    icode = 4'h6; mem_ready = 1'b0;
    step(4);
    chk("to_mem_entry", stage_en, 6'h08);
    step(15);
    chk("to_cycle16_mem", stage_en, 6'h08);
    chk("to_cycle16_stat", stat, 1);
    step(1);
    chk("timeout_stat", stat, 3);
    chk("timeout_en", stage_en, 0);
    step(2);
    chk("timeout_no_wb_pc", stage_en, 0);
    mem_ready = 1'b1;
    go_reset();
    step(4);
    dmem_error = 1'b1;
    step(1);
    chk("dmem_err_wins_stat", stat, 3);
    chk("dmem_err_done", done, 1);
    dmem_error = 1'b0;
    go_reset();
    alu_zf = 1'b0; alu_sf = 1'b1; alu_of = 1'b0;
    step(7);
    chk("pre_reset_cc", {zf, sf, of}, 3'b010);
    step(2);
    chk("in_execute", stage_en, 6'h04);
    reset = 1'b1;
    step(1);
    chk("midreset_en", stage_en, 0);
    chk("midreset_cc", {zf, sf, of}, 3'b100);
    chk("midreset_running", running, 0);
    chk("midreset_instr", instr_count, 0);
    chk("midreset_cycle", cycle_count, 0);
    reset = 1'b0;
    step(1);
    chk("resume_fetch", stage_en, 6'h01);
    lim_reset = 1'b0;
    step(1);
    chk("lim_fetch1", lim_stage_en, 6'h01);
    step(17);
    chk("lim_pcupd3_en", lim_stage_en, 6'h20);
    chk("lim_pcupd3_stat", lim_stat, 1);
    chk("lim_pcupd3_count", lim_instr_count, pc(2));
    step(1);
    chk("lim_halt_stat", lim_stat, 2);
    chk("lim_halt_done", lim_done, 1);
    chk("lim_halt_en", lim_stage_en, 0);
    chk("lim_instr_count_3", lim_instr_count, pc(3));
    step(2);
    chk("lim_absorb", lim_done, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
